// File: rtl/stopwatch_lap_control.sv
// Stopwatch run/lap/clear control FSM with registered outputs and button edge detection.
// Optional STOPWATCH_LAP_AUTOSTOP_EN: the lap that fills the last slot also stops timing.
module stopwatch_lap_control #(
  parameter int LAP_DEPTH   = 4,
  parameter int IDX_W       = 2,
  parameter int HOLD_CYCLES = 100000000,
  parameter int HOLD_W      = 27
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             buttonSt,
  input  logic             buttonFi,
  input  logic             buttonLap,
  input  logic             buttonClr,
  output logic             run,
  output logic             freeze,
  output logic             clear_count,
  output logic             lap_store,
  output logic [IDX_W-1:0] lap_index,
  output logic             lap_full,
  output logic [1:0]       state_out
);

  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(LAP_DEPTH);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    HOLD    = 2'b10,
    STOPPED = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        btn, prev_q, edg;
  logic [HOLD_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              run_q, run_d, freeze_q, freeze_d;
  logic              clear_q, clear_d, store_q, store_d, full_q, full_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic              act_st, act_fi, act_lap, act_clr, lap_ok;

  // Bit order {St, Fi, Lap, Clr}; only the highest-priority edge acts, St+Fi together cancel
  always_comb begin
    btn     = {buttonSt, buttonFi, buttonLap, buttonClr};
    edg     = btn & ~prev_q;
    act_st  = 1'b0;
    act_fi  = 1'b0;
    act_lap = 1'b0;
    act_clr = 1'b0;
    if (!(edg[3] && edg[2])) begin
      if (edg[2])      act_fi  = 1'b1;
      else if (edg[3]) act_st  = 1'b1;
      else if (edg[1]) act_lap = 1'b1;
      else if (edg[0]) act_clr = 1'b1;
    end
    lap_ok = act_lap && (count_q != DEPTH_C);
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    count_d = count_q;
    clear_d = 1'b0;
    store_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (act_st) begin
          state_d = RUNNING;
        end else if (act_clr) begin
          clear_d = 1'b1;
          count_d = '0;
        end
      end
      RUNNING, HOLD: begin
        if (state_q == HOLD) begin
          if (timer_q == '0) state_d = RUNNING;
          else               timer_d = timer_q - HOLD_W'(1);
        end
        if (act_fi) begin
          state_d = STOPPED;
          timer_d = '0;
        end else if (lap_ok) begin
          store_d = 1'b1;
          count_d = count_q + CNT_W'(1);
          timer_d = HOLD_LOAD;
          state_d = HOLD;
`ifdef STOPWATCH_LAP_AUTOSTOP_EN
          if (count_d == DEPTH_C) begin
            state_d = STOPPED;
            timer_d = '0;
          end
`endif
        end
      end
      STOPPED: begin
        if (act_st) begin
          state_d = RUNNING;
        end else if (act_clr) begin
          clear_d = 1'b1;
          count_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    run_d    = (state_d == RUNNING) || (state_d == HOLD);
    freeze_d = (state_d == HOLD);
    full_d   = (count_d == DEPTH_C);
    // During the strobe the index names the slot being written, otherwise the live count
    index_d  = store_d ? count_q[IDX_W-1:0] : count_d[IDX_W-1:0];
  end

  always_ff @(posedge clock) begin
    prev_q <= btn;
    if (reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      count_q  <= '0;
      run_q    <= 1'b0;
      freeze_q <= 1'b0;
      clear_q  <= 1'b0;
      store_q  <= 1'b0;
      full_q   <= 1'b0;
      index_q  <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      count_q  <= count_d;
      run_q    <= run_d;
      freeze_q <= freeze_d;
      clear_q  <= clear_d;
      store_q  <= store_d;
      full_q   <= full_d;
      index_q  <= index_d;
    end
  end

  assign run         = run_q;
  assign freeze      = freeze_q;
  assign clear_count = clear_q;
  assign lap_store   = store_q;
  assign lap_index   = index_q;
  assign lap_full    = full_q;
  assign state_out   = state_q;

endmodule

// File: doc/stopwatch_lap_control.md
Name: stopwatch_lap_control

Overview:
Control FSM for the next-generation stopwatch. It adds lap capture, display freeze, clear and pause/resume on top of the existing start/finish run control.
- Sits between the debounced button synchronisers and the counter/display datapath.
- Drives the counter enable, the counter clear, the display freeze and the lap-register write strobes.
- Lap storage depth is parametrised.

Parameters:
LAP_DEPTH, 4, number of lap slots in the datapath lap register file (1..2**IDX_W)
IDX_W, 2, width of lap_index
HOLD_CYCLES, 100000000, clock cycles the display stays frozen after a lap capture (1 s at 100 MHz)
HOLD_W, 27, width of the hold timer; must satisfy 2**HOLD_W > HOLD_CYCLES

Ports:
clock  input  1  system clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset
buttonSt  input  1  start/resume button level, debounced
buttonFi  input  1  finish/stop button level, debounced
buttonLap  input  1  lap button level, debounced
buttonClr  input  1  clear button level, debounced
run  output  1  counter enable
freeze  output  1  display shows latched lap value instead of live count
clear_count  output  1  one-cycle pulse that zeroes the counter
lap_store  output  1  one-cycle write strobe to the lap register file
lap_index  output  IDX_W  slot written on lap_store; equals number of laps already stored
lap_full  output  1  all LAP_DEPTH slots used
state_out  output  2  current state encoding, for debug LEDs

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous and active-high.
- Edge detection:
  - Each button has a previous-value register; edge_x = button_x & ~prev_x.
  - All actions act on rising edges only. Holding a button causes exactly one action.
  - During reset, each prev_x loads the current button level, so a button held through reset release produces no edge.
- States (2-bit): IDLE=00, RUNNING=01, HOLD=10, STOPPED=11.
- Outputs are registered. Any action takes effect on the clock edge that samples the button edge, so it is visible the cycle after the button rises.
- Reset values: state IDLE; run 0; freeze 0; clear_count 0; lap_store 0; lap_index 0; lap_full 0; hold timer 0.
- Simultaneous-edge rules:
  - edge_St and edge_Fi in the same cycle: both ignored, state held.
  - Otherwise priority is Fi > St > Lap > Clr.
- Transitions:
  - IDLE: edge_St -> RUNNING. edge_Clr -> pulse clear_count, zero lap_index/lap_full, stay IDLE. Others ignored.
  - RUNNING: edge_Fi -> STOPPED. edge_Lap with lap_full=0 -> pulse lap_store (lap_index = current count), increment count, load hold timer with HOLD_CYCLES-1, go to HOLD. edge_Lap with lap_full=1 -> ignored. edge_Clr ignored.
  - HOLD: run stays 1 and freeze=1. Timer decrements each cycle; at 0 -> RUNNING. edge_Lap (not full) -> store the next lap and reload the timer, stay HOLD. edge_Fi -> STOPPED with freeze cleared.
  - STOPPED: edge_St -> RUNNING (resume, counter not cleared). edge_Clr -> clear_count pulse, laps zeroed, go to IDLE.
- Illegal or unreachable encodings are not possible with 2 bits. The default case goes to IDLE.
- Output decode:
  - run = 1 in RUNNING and HOLD.
  - freeze = 1 only in HOLD.
  - state_out = state.
- Lap counter:
  - Counts 0..LAP_DEPTH. lap_full = (count == LAP_DEPTH).
  - lap_index = count truncated to IDX_W and is only meaningful while lap_full=0.
  - The counter never wraps; only clear or reset zeroes it.
- Pulses: clear_count and lap_store are high for exactly one cycle per accepted edge and never both in the same cycle.
- Reset mid-operation: reset overrides everything on that edge. Pending hold is abandoned; freeze and run drop the next cycle.

Optional Feature:
STOPWATCH_LAP_AUTOSTOP_EN
- Defined: the lap capture that makes lap_full=1 also stops timing. The FSM goes to STOPPED instead of HOLD and freeze stays 0. The final lap is still stored with its lap_store pulse.
- Undefined: timing continues after the last slot fills, and further lap edges are ignored as above.

Test Plan:
- Reset with buttonSt held high, release reset, keep holding -> state stays IDLE, run=0. Release then press buttonSt -> run=1 one cycle after the sampling edge.
- IDLE -> start, press lap (HOLD_CYCLES=10 in test) -> lap_store pulse with lap_index=0 and freeze=1 for exactly 10 cycles, then freeze=0 with run still 1.
- Press lap 5 times with LAP_DEPTH=4 -> four lap_store pulses with lap_index 0,1,2,3, lap_full=1 after the fourth, fifth press produces no pulse. With the macro defined, run=0 after the fourth.
- In RUNNING, raise buttonSt and buttonFi on the same cycle -> no state change. Raise Fi alone -> STOPPED, run=0. Press St -> RUNNING, no clear_count.
- In STOPPED with 2 laps stored, press clear -> one-cycle clear_count, lap_index=0, lap_full=0, state IDLE. Press clear in RUNNING -> no effect.
- Assert reset during HOLD -> next cycle all outputs 0, state_out=00.
